// File: rtl/graph_loader.sv
`default_nettype none
// graph_loader: collects undirected edges into a flat adjacency matrix, holds the
// finished graph for a consumer, then flushes for the next one.  Rev 1.0
module graph_loader #(
  parameter int N_NODES = 3,
  localparam int IW = ($clog2(N_NODES) < 1) ? 1 : $clog2(N_NODES),
  localparam int CW = $clog2(N_NODES * (N_NODES - 1) / 2 + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         edge_valid,
  output logic                         edge_ready,
  input  logic [IW-1:0]                edge_src,
  input  logic [IW-1:0]                edge_dst,
  input  logic                         edge_last,
  output logic [N_NODES*N_NODES-1:0]   graph,
  output logic                         graph_valid,
  input  logic                         graph_ack,
  output logic [CW-1:0]                edge_count,
  output logic [3:0]                   err_count
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [IW:0] N_LIM = (IW + 1)'(N_NODES);

  state_t                       state, state_nx;
  logic                         accept, in_range, good_edge, is_new, go_flush;
  logic [N_NODES*N_NODES-1:0]   mask;

  assign edge_ready  = (state == LOAD);
  assign graph_valid = (state == HOLD);
  // clear wins over acceptance in the same cycle
  assign accept      = edge_valid && edge_ready && !clear;
  assign in_range    = ({1'b0, edge_src} < N_LIM) && ({1'b0, edge_dst} < N_LIM);
  assign good_edge   = in_range && (edge_src != edge_dst);
  assign is_new      = ((graph & mask) == '0);
  assign go_flush    = (state_nx == FLUSH);

  always_comb begin
    mask = '0;
    for (int i = 0; i < N_NODES; i++) begin
      for (int j = 0; j < N_NODES; j++) begin
        if ((edge_src == IW'(i) && edge_dst == IW'(j)) ||
            (edge_src == IW'(j) && edge_dst == IW'(i)))
          mask[i*N_NODES+j] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (accept && edge_last) state_nx = HOLD;
      HOLD:    if (graph_ack) state_nx = FLUSH;
      FLUSH:   state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
    if (clear) state_nx = FLUSH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nx;
  end

  // Contents are zeroed on entry to FLUSH so the flush cycle already shows 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      graph      <= '0;
      edge_count <= '0;
      err_count  <= '0;
    end else if (go_flush) begin
      graph      <= '0;
      edge_count <= '0;
      err_count  <= '0;
    end else if (accept) begin
      if (good_edge) begin
        graph <= graph | mask;
        if (is_new) edge_count <= edge_count + CW'(1);
      end else if (err_count != 4'hF) begin
        err_count <= err_count + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_graph_loader.sv
`default_nettype none
// Self-checking bench for graph_loader (N_NODES=3): vector table plus
// hand-written multi-cycle sequences, with a scoreboard queue of expectations.
module tb_graph_loader;

  logic       clk = 1'b0;
  logic       rst_n, clear, edge_valid, edge_last, graph_ack;
  logic       edge_ready, graph_valid;
  logic [1:0] edge_src, edge_dst, edge_count;
  logic [8:0] graph;
  logic [3:0] err_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] s, d;
    logic       l;
    logic [8:0] g;
    logic [1:0] c;
    logic [3:0] e;
    logic       ack;
  } vec_t;

  typedef struct {
    logic [8:0] g;
    logic [1:0] c;
    logic [3:0] e;
    logic       v;
  } exp_t;

  exp_t sb[$];

  graph_loader #(.N_NODES(3)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .edge_valid(edge_valid),
    .edge_ready(edge_ready), .edge_src(edge_src), .edge_dst(edge_dst),
    .edge_last(edge_last), .graph(graph), .graph_valid(graph_valid),
    .graph_ack(graph_ack), .edge_count(edge_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; offers one edge, waits (bounded) for acceptance, checks result.
  task automatic apply(input logic [1:0] s, input logic [1:0] d, input logic l,
                       input logic [8:0] eg, input logic [1:0] ec, input logic [3:0] ee);
    exp_t x;
    int   w;
    x.g = eg; x.c = ec; x.e = ee; x.v = l;
    sb.push_back(x);
    edge_src = s; edge_dst = d; edge_last = l; edge_valid = 1'b1;
    w = 0;
    while (!edge_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!edge_ready) chk("accept_timeout", 32'(edge_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    edge_valid = 1'b0; edge_last = 1'b0;
    x = sb.pop_front();
    chk("graph", 32'(graph), 32'(x.g));
    chk("edge_count", 32'(edge_count), 32'(x.c));
    chk("err_count", 32'(err_count), 32'(x.e));
    chk("graph_valid", 32'(graph_valid), 32'(x.v));
  endtask

  // Called at a negedge in HOLD; pulses graph_ack and checks FLUSH then LOAD.
  task automatic ack_graph();
    graph_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    graph_ack = 1'b0;
    chk("flush_graph", 32'(graph), 32'd0);
    chk("flush_ready", 32'(edge_ready), 32'd0);
    chk("flush_valid", 32'(graph_valid), 32'd0);
    chk("flush_count", 32'(edge_count), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("load_ready", 32'(edge_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    vecs[0] = '{s:2'd0, d:2'd1, l:1'b0, g:9'h00A, c:2'd1, e:4'd0, ack:1'b0};
    vecs[1] = '{s:2'd1, d:2'd2, l:1'b1, g:9'h0AA, c:2'd2, e:4'd0, ack:1'b1};
    vecs[2] = '{s:2'd0, d:2'd1, l:1'b0, g:9'h00A, c:2'd1, e:4'd0, ack:1'b0};
    vecs[3] = '{s:2'd1, d:2'd0, l:1'b0, g:9'h00A, c:2'd1, e:4'd0, ack:1'b0};
    vecs[4] = '{s:2'd0, d:2'd1, l:1'b1, g:9'h00A, c:2'd1, e:4'd0, ack:1'b1};
    vecs[5] = '{s:2'd2, d:2'd2, l:1'b0, g:9'h000, c:2'd0, e:4'd1, ack:1'b0};
    vecs[6] = '{s:2'd3, d:2'd0, l:1'b1, g:9'h000, c:2'd0, e:4'd2, ack:1'b1};
    vecs[7] = '{s:2'd2, d:2'd1, l:1'b0, g:9'h0A0, c:2'd1, e:4'd0, ack:1'b0};
    vecs[8] = '{s:2'd0, d:2'd2, l:1'b1, g:9'h0E4, c:2'd2, e:4'd0, ack:1'b1};

    rst_n = 1'b0; clear = 1'b0; edge_valid = 1'b0; edge_last = 1'b0;
    graph_ack = 1'b0; edge_src = 2'd0; edge_dst = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_graph", 32'(graph), 32'd0);
    chk("rst_count", 32'(edge_count), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_valid", 32'(graph_valid), 32'd0);
    chk("rst_ready", 32'(edge_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].s, vecs[i].d, vecs[i].l, vecs[i].g, vecs[i].c, vecs[i].e);
      if (vecs[i].ack) ack_graph();
    end

    // Edge held during HOLD must not be consumed until LOAD returns.
    apply(2'd0, 2'd1, 1'b1, 9'h00A, 2'd1, 4'd0);
    edge_src = 2'd1; edge_dst = 2'd2; edge_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_ready", 32'(edge_ready), 32'd0);
      chk("hold_graph", 32'(graph), 32'h00A);
    end
    graph_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    graph_ack = 1'b0;
    chk("hold_flush_graph", 32'(graph), 32'd0);
    chk("hold_flush_ready", 32'(edge_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("reload_ready", 32'(edge_ready), 32'd1);
    chk("reload_graph", 32'(graph), 32'd0);
    @(posedge clk);
    @(negedge clk);
    edge_valid = 1'b0;
    chk("held_edge_graph", 32'(graph), 32'h0A0);
    chk("held_edge_count", 32'(edge_count), 32'd1);

    // clear beats a simultaneous edge
    clear = 1'b1; edge_valid = 1'b1; edge_src = 2'd0; edge_dst = 2'd1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0; edge_valid = 1'b0;
    chk("clear_graph", 32'(graph), 32'd0);
    chk("clear_count", 32'(edge_count), 32'd0);
    chk("clear_ready", 32'(edge_ready), 32'd0);
    chk("clear_valid", 32'(graph_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("clear_reload_ready", 32'(edge_ready), 32'd1);

    // err_count saturation
    for (int k = 1; k <= 20; k++) begin
      apply((k % 2) ? 2'd3 : 2'd1, (k % 2) ? 2'd1 : 2'd1, 1'b0, 9'h000, 2'd0,
            (k > 15) ? 4'd15 : 4'(k));
    end
    apply(2'd0, 2'd0, 1'b1, 9'h000, 2'd0, 4'd15);
    ack_graph();

    // asynchronous reset mid-load
    apply(2'd0, 2'd1, 1'b0, 9'h00A, 2'd1, 4'd0);
    apply(2'd0, 2'd2, 1'b0, 9'h04E, 2'd2, 4'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_graph", 32'(graph), 32'd0);
    chk("async_rst_count", 32'(edge_count), 32'd0);
    chk("async_rst_ready", 32'(edge_ready), 32'd1);
    chk("async_rst_valid", 32'(graph_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(2'd1, 2'd2, 1'b0, 9'h0A0, 2'd1, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
